// File: rtl/scan_sel_gen.sv
// Scan sequencer for a 3-to-8 one-hot decoder: steps sel through 0..last,
// holding each position enabled for DWELL_CNT clocks, then blanked for BLANK_CNT clocks.
module scan_sel_gen #(
    parameter int DWELL_CNT = 50000,
    parameter int BLANK_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [2:0] num_pos,
    output logic [2:0] sel,
    output logic       sel_en,
    output logic       frame_done
);

    localparam int CNT_MAX = (DWELL_CNT > BLANK_CNT) ? DWELL_CNT : BLANK_CNT;
    localparam int CW      = $clog2((CNT_MAX > 2) ? CNT_MAX : 2);

    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CNT - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CNT > 0) ? (BLANK_CNT - 1) : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [2:0]    last, last_next;
    logic [2:0]    sel_next;
    logic          sel_en_next;
    logic          frame_done_next;
    logic          advance;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last       <= '0;
            sel        <= '0;
            sel_en     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            last       <= last_next;
            sel        <= sel_next;
            sel_en     <= sel_en_next;
            frame_done <= frame_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        last_next       = last;
        sel_next        = sel;
        sel_en_next     = sel_en;
        frame_done_next = 1'b0;
        advance         = 1'b0;

        case (state)
            IDLE: begin
                sel_next    = '0;
                sel_en_next = 1'b0;
                cnt_next    = '0;
                if (run) begin
                    state_next  = SHOW;
                    sel_en_next = 1'b1;
                    last_next   = num_pos;
                end
            end

            SHOW: begin
                if (!run) begin
                    state_next  = IDLE;
                    sel_next    = '0;
                    sel_en_next = 1'b0;
                    cnt_next    = '0;
                end else if (cnt == DWELL_LAST) begin
                    if (BLANK_CNT > 0) begin
                        state_next  = BLANK;
                        cnt_next    = '0;
                        sel_en_next = 1'b0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            BLANK: begin
                if (!run) begin
                    state_next  = IDLE;
                    sel_next    = '0;
                    sel_en_next = 1'b0;
                    cnt_next    = '0;
                end else if (cnt == BLANK_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end

            default: begin
                state_next  = IDLE;
                sel_next    = '0;
                sel_en_next = 1'b0;
                cnt_next    = '0;
            end
        endcase

        // Stop requests are handled above, so advancing always continues scanning.
        if (advance) begin
            state_next  = SHOW;
            sel_en_next = 1'b1;
            cnt_next    = '0;
            if (sel == last) begin
                sel_next        = '0;
                frame_done_next = 1'b1;
                last_next       = num_pos;
            end else begin
                sel_next = sel + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_scan_sel_gen.sv
// Bench for scan_sel_gen: a frame-time reference model checked every cycle on
// a blanking and a no-blank instance, plus directed literal pins and random traffic.
module tb_scan_sel_gen;

    localparam int DWELL  = 3;
    localparam int PER    = 4;
    localparam int PER_NB = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run, nb_run;
    logic [2:0] num_pos, nb_num_pos;
    logic [2:0] sel, nb_sel;
    logic       sel_en, nb_sel_en;
    logic       frame_done, nb_frame_done;

    int n_vec = 0;
    int n_err = 0;

    scan_sel_gen #(.DWELL_CNT(3), .BLANK_CNT(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .num_pos    (num_pos),
        .sel        (sel),
        .sel_en     (sel_en),
        .frame_done (frame_done)
    );

    scan_sel_gen #(.DWELL_CNT(3), .BLANK_CNT(0)) dut_nb (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (nb_run),
        .num_pos    (nb_num_pos),
        .sel        (nb_sel),
        .sel_en     (nb_sel_en),
        .frame_done (nb_frame_done)
    );

    always #5 clk = ~clk;

    // Model state: t is clocks elapsed since the current frame started.
    typedef struct {
        bit active;
        int t;
        int last;
        bit fd;
    } model_t;

    model_t m1, m2;

    function automatic model_t model_next(model_t m, logic go, int np, int period);
        model_t n = m;
        n.fd = 1'b0;
        if (!m.active) begin
            if (go) begin
                n.active = 1'b1;
                n.t      = 0;
                n.last   = np;
            end
        end else if (!go) begin
            n.active = 1'b0;
            n.t      = 0;
        end else begin
            n.t = m.t + 1;
            if (n.t == (m.last + 1) * period) begin
                n.t    = 0;
                n.fd   = 1'b1;
                n.last = np;
            end
        end
        return n;
    endfunction

    function automatic int model_sel(model_t m, int period);
        return m.active ? (m.t / period) : 0;
    endfunction

    function automatic int model_en(model_t m, int period);
        return (m.active && ((m.t % period) < DWELL)) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 = '{default: 0};
            m2 = '{default: 0};
        end else begin
            m1 = model_next(m1, run, int'(num_pos), PER);
            m2 = model_next(m2, nb_run, int'(nb_num_pos), PER_NB);
        end
    end

    task automatic check_output(string name, logic [31:0] actual, logic [31:0] expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic check_cycle();
        logic [7:0] dec_dut, dec_mdl;
        check_output("sel", 32'(sel), 32'(model_sel(m1, PER)));
        check_output("sel_en", 32'(sel_en), 32'(model_en(m1, PER)));
        check_output("frame_done", 32'(frame_done), 32'(m1.fd));
        dec_dut = sel_en ? (8'h01 << sel) : 8'h00;
        dec_mdl = (model_en(m1, PER) != 0) ? (8'h01 << model_sel(m1, PER)) : 8'h00;
        check_output("dec_out", 32'(dec_dut), 32'(dec_mdl));
        check_output("dec_multi_hot", 32'($countones(dec_dut) > 1), 32'd0);
        check_output("nb_sel", 32'(nb_sel), 32'(model_sel(m2, PER_NB)));
        check_output("nb_sel_en", 32'(nb_sel_en), 32'(model_en(m2, PER_NB)));
        check_output("nb_frame_done", 32'(nb_frame_done), 32'(m2.fd));
    endtask

    always @(negedge clk) begin
        if (rst_n) check_cycle();
    end

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Literal expectations applied to both the DUT and the model.
    task automatic pin_out(string tag, int s, int e, int f);
        check_output({tag, "_sel"}, 32'(sel), 32'(s));
        check_output({tag, "_en"}, 32'(sel_en), 32'(e));
        check_output({tag, "_fd"}, 32'(frame_done), 32'(f));
        check_output({tag, "_model_sel"}, 32'(model_sel(m1, PER)), 32'(s));
        check_output({tag, "_model_en"}, 32'(model_en(m1, PER)), 32'(e));
        check_output({tag, "_model_fd"}, 32'(m1.fd), 32'(f));
    endtask

    task automatic pin_nb(string tag, int s, int e, int f);
        check_output({tag, "_sel"}, 32'(nb_sel), 32'(s));
        check_output({tag, "_en"}, 32'(nb_sel_en), 32'(e));
        check_output({tag, "_fd"}, 32'(nb_frame_done), 32'(f));
        check_output({tag, "_model_sel"}, 32'(model_sel(m2, PER_NB)), 32'(s));
        check_output({tag, "_model_fd"}, 32'(m2.fd), 32'(f));
    endtask

    task automatic apply_stimulus(int cycles);
        for (int i = 0; i < cycles; i++) begin
            tick(1);
            if ($urandom_range(0, 99) < 3) run = ~run;
            else if (!run && $urandom_range(0, 99) < 30) run = 1'b1;
            if ($urandom_range(0, 99) < 5) num_pos = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 99) < 3) nb_run = ~nb_run;
            else if (!nb_run && $urandom_range(0, 99) < 30) nb_run = 1'b1;
            if ($urandom_range(0, 99) < 5) nb_num_pos = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 999) < 3) begin
                rst_n = 1'b0;
                #2;
                pin_out("rand_rst", 0, 0, 0);
                tick(1);
                rst_n = 1'b1;
            end
        end
    endtask

    initial begin
        run        = 1'b0;
        num_pos    = 3'd0;
        nb_run     = 1'b0;
        nb_num_pos = 3'd0;
        #23;
        pin_out("reset", 0, 0, 0);
        rst_n = 1'b1;

        // No-blank instance: two positions toggling every 3 clocks.
        tick(1);
        nb_num_pos = 3'd1;
        nb_run     = 1'b1;
        tick(1); pin_nb("nb_start", 0, 1, 0);
        tick(3); pin_nb("nb_pos1", 1, 1, 0);
        tick(3); pin_nb("nb_frame", 0, 1, 1);
        tick(1); pin_nb("nb_after", 0, 1, 0);

        // Full 8-position sweep.
        num_pos = 3'd7;
        run     = 1'b1;
        tick(1);  pin_out("start", 0, 1, 0);
        tick(31); pin_out("sweep_last_blank", 7, 0, 0);
        tick(1);  pin_out("sweep_done", 0, 1, 1);
        tick(1);  pin_out("sweep_after", 0, 1, 0);

        // Short frame, num_pos changed mid-frame.
        num_pos = 3'd2;
        tick(31); pin_out("short_latch", 0, 1, 1);
        tick(4);  pin_out("short_pos1", 1, 1, 0);
        tick(4);  pin_out("short_pos2", 2, 1, 0);
        tick(3);  pin_out("short_blank2", 2, 0, 0);
        tick(1);  pin_out("short_frame2", 0, 1, 1);
        tick(5);
        num_pos = 3'd5;
        tick(7);  pin_out("short_frame3", 0, 1, 1);
        tick(12); pin_out("grow_pos3", 3, 1, 0);
        tick(12); pin_out("grow_frame", 0, 1, 1);

        // Stop during the blank of position 4.
        tick(19); pin_out("stop_blank4", 4, 0, 0);
        run = 1'b0;
        tick(1);  pin_out("stop_idle", 0, 0, 0);
        tick(2);  pin_out("stop_hold", 0, 0, 0);
        run = 1'b1;
        tick(1);  pin_out("restart", 0, 1, 0);

        // Asynchronous reset mid-dwell at position 2.
        tick(9);  pin_out("pre_reset", 2, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        pin_out("async_reset", 0, 0, 0);
        tick(1);
        rst_n = 1'b1;
        tick(1);  pin_out("post_reset", 0, 1, 0);

        apply_stimulus(3000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        n_err++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
